ahb_burst_master: RTL and testbench
===================================

AHB_BURST_MASTER -- requirements
Module: ahb_burst_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning HADDR/cmd_addr width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning HWDATA/HRDATA width; only 32 is supported.
REQ-003 SHALL have port hclk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port hresetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  in  1  command request.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_write  in  1  1=write burst, 0=read burst.
REQ-008 SHALL have port cmd_addr  in  ADDR_W  start byte address.
REQ-009 SHALL have port cmd_burst  in  3  HBURST code; INCR (001) is rejected.
REQ-010 SHALL have port wdata  in  32  write beat data.
REQ-011 SHALL have port wdata_valid / wdata_ready  in / out  1 each  write beat handshake.
REQ-012 SHALL have port rdata  out  32  read beat data.
REQ-013 SHALL have port rdata_valid  out  1  one-cycle pulse per read beat.
REQ-014 SHALL have port done  out  1  one-cycle pulse at command completion.
REQ-015 SHALL have port cmd_err  out  1  one-cycle pulse on command rejection or bus ERROR.
REQ-016 SHALL have ports haddr[31:0], htrans[1:0], hwrite, hsize[2:0], hburst[2:0], hwdata[31:0]  out; hready, hresp[1:0], hrdata[31:0]  in  AHB master side.

Function
REQ-017 SHALL implement states IDLE, ADDR, BURST, LAST, ERR.
REQ-018 SHALL drive cmd_ready=1 only in IDLE.
REQ-019 SHALL reject a command (cmd_err pulse the next cycle, no bus activity, stay IDLE) when cmd_addr[1:0]!=0, cmd_burst==INCR, or an INCR4/8/16 burst would cross a 1 KB boundary.
REQ-020 SHALL, for an accepted command in cycle N, drive htrans=NONSEQ with haddr=cmd_addr in cycle N+1 (ADDR); for a write, NONSEQ is held off (htrans=IDLE) until wdata_valid=1.
REQ-021 SHALL drive hsize=010 (word) always; hburst=cmd_burst for the whole burst.
REQ-022 SHALL advance an address phase only when hready=1; all master outputs hold while hready=0.
REQ-023 SHALL issue beats 2..N (N=4/8/16, SINGLE N=1) as SEQ with address +4; WRAP bursts wrap within an N*4-byte aligned block (e.g. WRAP4 from 0x08: 0x08,0x0C,0x00,0x04).
REQ-024 SHALL, for writes, pulse wdata_ready when a beat's address phase is accepted and present that wdata on hwdata in the following data phase.
REQ-025 SHALL drive htrans=BUSY (haddr held at the next beat address) for a SEQ beat whose wdata_valid=0, resuming SEQ when wdata_valid=1.
REQ-026 SHALL, for reads, pulse rdata_valid with rdata=hrdata on each data phase completed with hready=1 and hresp=OKAY.
REQ-027 SHALL enter LAST after the final address phase, drive htrans=IDLE, pulse done when the final data phase completes, then return to IDLE.
REQ-028 SHALL, on hresp=ERROR with hready=0 (first error cycle), drive htrans=IDLE in the next cycle, cancel remaining beats, enter ERR, pulse cmd_err (no done), and return to IDLE.
REQ-029 SHALL treat hresp RETRY/SPLIT as ERROR.

Reset
REQ-030 SHALL, while hresetn=0, force state=IDLE, htrans=IDLE, haddr=0, hwrite=0, hburst=000, hsize=010, hwdata=0, cmd_ready=0, wdata_ready=0, rdata=0, rdata_valid=0, done=0, cmd_err=0.
REQ-031 SHALL abandon any in-flight burst on reset assertion, with no done or cmd_err pulse; cmd_ready=1 in the first cycle after deassertion.

Configuration
REQ-032 SHALL, with AHB_MASTER_WRAP_EN defined, support WRAP4/8/16 per REQ-023.
REQ-033 SHALL, without AHB_MASTER_WRAP_EN, reject WRAP4/8/16 commands per REQ-019.

Verification
REQ-034 SHALL cover a SINGLE write to 0x04, data 0x1, hready=1: NONSEQ cycle N+1, hwdata=0x1 cycle N+2, done in cycle N+2.
REQ-035 SHALL cover an INCR4 read at 0x10 with one hready=0 wait per beat: haddr 0x10,0x14,0x18,0x1C held during waits, 4 rdata_valid pulses, one done.
REQ-036 SHALL cover a WRAP4 write at 0x08 with wdata_valid low for 2 cycles before beat 3: addresses 0x08,0x0C,0x00,0x04, two BUSY cycles.
REQ-037 SHALL cover an INCR8 command at 0x3FF0: cmd_err pulse, htrans stays IDLE.
REQ-038 SHALL cover an INCR4 write where the slave returns ERROR on beat 2: htrans=IDLE in the second error cycle, no further beats, cmd_err pulsed, no done.
REQ-039 SHALL cover hresetn asserted mid-INCR16: all outputs at reset values immediately, cmd_ready=1 after release.

Source files
------------

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: turns a cmd / wdata / rdata handshake into SINGLE, INCR4/8/16 and WRAP4/8/16 bursts.
// Define AHB_MASTER_WRAP_EN to accept WRAP4/8/16; without it those commands are rejected like any other illegal command.
module ahb_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              cmd_err,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic [1:0]        hresp,
    input  logic [DATA_W-1:0] hrdata
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_haddr;
    logic [2:0]        r_hburst;
    logic              r_hwrite;
    logic [DATA_W-1:0] r_hwdata;
    logic [4:0]        r_beats_left;
    logic              r_is_wrap;
    logic [5:0]        r_wmask;
    logic              r_dphase;
    logic              r_dlast;
    logic              r_cmd_err;

    logic [4:0]        w_cmd_len;
    logic [6:0]        w_cmd_bytes;
    logic [10:0]       w_cmd_end;
    logic              w_cmd_wrap;
    logic              w_cmd_incrn;
    logic              w_reject;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_mask;
    logic [ADDR_W-1:0] w_next;
    logic              w_addr_active;
    logic              w_err;
    logic              w_accept;
    logic              w_dcomp;

    // Command legality: alignment, no undefined-length INCR, no 1 KB crossing for fixed INCRs.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_cmd_len = 5'd1;
        case (cmd_burst[2:1])
            2'b01:   w_cmd_len = 5'd4;
            2'b10:   w_cmd_len = 5'd8;
            2'b11:   w_cmd_len = 5'd16;
            default: w_cmd_len = 5'd1;
        endcase
        w_cmd_bytes = {w_cmd_len, 2'b00};
        w_cmd_end   = {1'b0, cmd_addr[9:0]} + {4'b0000, w_cmd_bytes};
        w_cmd_wrap  = !cmd_burst[0] && (cmd_burst != 3'b000);
        w_cmd_incrn = cmd_burst[0] && (cmd_burst[2:1] != 2'b00);
        w_reject    = (cmd_addr[1:0] != 2'b00) || (cmd_burst == 3'b001)
                   || (w_cmd_incrn && (w_cmd_end > 11'd1024));
`ifndef AHB_MASTER_WRAP_EN
        w_reject    = w_reject || w_cmd_wrap;
`endif
    end

    // WRAP bursts keep the bits above the N*4 block and only let the low bits roll over.
    assign w_inc  = r_haddr + ADDR_W'(4);
    assign w_mask = r_is_wrap ? ADDR_W'(r_wmask) : '1;
    assign w_next = (r_haddr & ~w_mask) | (w_inc & w_mask);

    // A write beat only goes on the bus once its data is available; reads always go.
    assign w_addr_active = ((r_state == S_ADDR) || (r_state == S_BURST)) && (!r_hwrite || wdata_valid);
    assign w_err         = r_dphase && (hresp != 2'b00);
    assign w_accept      = w_addr_active && hready && !w_err;
    assign w_dcomp       = r_dphase && hready && !w_err;

    always_comb begin
        htrans = HT_IDLE;
        if (w_addr_active)
            htrans = (r_state == S_ADDR) ? HT_NONSEQ : HT_SEQ;
        else if (r_state == S_BURST)
            htrans = HT_BUSY;
    end

    assign cmd_ready   = (r_state == S_IDLE) && hresetn;
    assign wdata_ready = w_accept && r_hwrite;
    assign rdata_valid = w_dcomp && !r_hwrite;
    assign rdata       = rdata_valid ? hrdata : '0;
    assign done        = w_dcomp && r_dlast;
    assign cmd_err     = r_cmd_err;
    assign haddr       = r_haddr;
    assign hwrite      = r_hwrite;
    assign hsize       = 3'b010;
    assign hburst      = r_hburst;
    assign hwdata      = r_hwdata;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state      <= S_IDLE;
            r_haddr      <= '0;
            r_hburst     <= 3'b000;
            r_hwrite     <= 1'b0;
            r_hwdata     <= '0;
            r_beats_left <= 5'd0;
            r_is_wrap    <= 1'b0;
            r_wmask      <= 6'd0;
            r_dphase     <= 1'b0;
            r_dlast      <= 1'b0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_cmd_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (w_reject) begin
                            r_cmd_err <= 1'b1;
                        end else begin
                            r_haddr      <= cmd_addr;
                            r_hburst     <= cmd_burst;
                            r_hwrite     <= cmd_write;
                            r_beats_left <= w_cmd_len;
                            r_is_wrap    <= w_cmd_wrap;
                            r_wmask      <= w_cmd_bytes[5:0] - 6'd1;
                            r_state      <= S_ADDR;
                        end
                    end
                end
                S_ADDR, S_BURST: begin
                    if (w_err) begin
                        r_dphase  <= 1'b0;
                        r_cmd_err <= 1'b1;
                        r_state   <= S_ERR;
                    end else if (w_accept) begin
                        r_dphase     <= 1'b1;
                        r_dlast      <= (r_beats_left == 5'd1);
                        r_beats_left <= r_beats_left - 5'd1;
                        if (r_hwrite)
                            r_hwdata <= wdata;
                        if (r_beats_left == 5'd1) begin
                            r_state <= S_LAST;
                        end else begin
                            r_haddr <= w_next;
                            r_state <= S_BURST;
                        end
                    end else if (hready) begin
                        r_dphase <= 1'b0;
                    end
                end
                S_LAST: begin
                    if (w_err) begin
                        r_dphase  <= 1'b0;
                        r_cmd_err <= 1'b1;
                        r_state   <= S_ERR;
                    end else if (hready) begin
                        r_dphase <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (hready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Randomised bench for ahb_burst_master: a transaction-level model (beat address lists, reject rules)
// plus a small AHB slave that injects wait states and two-cycle ERROR responses.
module tb_ahb_burst_master;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

`ifdef AHB_MASTER_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic        hclk;
    logic        hresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_burst;
    logic [31:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        done;
    logic        cmd_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    int total = 0;
    int bad   = 0;

    ahb_burst_master dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_burst   (cmd_burst),
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .done        (done),
        .cmd_err     (cmd_err),
        .haddr       (haddr),
        .htrans      (htrans),
        .hwrite      (hwrite),
        .hsize       (hsize),
        .hburst      (hburst),
        .hwdata      (hwdata),
        .hready      (hready),
        .hresp       (hresp),
        .hrdata      (hrdata)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int beats_of(input logic [2:0] b);
        case (b)
            3'b000:         return 1;
            3'b010, 3'b011: return 4;
            3'b100, 3'b101: return 8;
            default:        return 16;
        endcase
    endfunction

    function automatic bit is_wrap(input logic [2:0] b);
        return (b == 3'b010) || (b == 3'b100) || (b == 3'b110);
    endfunction

    function automatic bit model_reject(input logic [31:0] a, input logic [2:0] b);
        int n;
        n = beats_of(b);
        if (a[1:0] != 2'b00) return 1'b1;
        if (b == 3'b001) return 1'b1;
        if (is_wrap(b) && !WRAP_EN) return 1'b1;
        if (!is_wrap(b) && (b != 3'b000) && (int'(a % 1024) + n * 4 > 1024)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] b, input int k);
        logic [31:0] blk;
        logic [31:0] base;
        blk = 32'(beats_of(b) * 4);
        if (is_wrap(b)) begin
            base = a - (a % blk);
            return base + ((a - base + 32'(4 * k)) % blk);
        end
        return a + 32'(4 * k);
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_htrans"},  htrans,      HT_IDLE);
        check({tag, "_haddr"},   haddr,       32'h0);
        check({tag, "_hwrite"},  hwrite,      1'b0);
        check({tag, "_hburst"},  hburst,      3'b000);
        check({tag, "_hsize"},   hsize,       3'b010);
        check({tag, "_hwdata"},  hwdata,      32'h0);
        check({tag, "_cmdrdy"},  cmd_ready,   1'b0);
        check({tag, "_wready"},  wdata_ready, 1'b0);
        check({tag, "_rdata"},   rdata,       32'h0);
        check({tag, "_rvalid"},  rdata_valid, 1'b0);
        check({tag, "_done"},    done,        1'b0);
        check({tag, "_cmderr"},  cmd_err,     1'b0);
    endtask

    // Issues one command and plays the slave until completion. Starts and ends just after a rising edge.
    // wait_pct < 0 means exactly one wait state per data phase; err_beat < 0 means no bus error.
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] burst,
                           input int err_beat, input int wait_pct, input int gap_pct,
                           input int hold_beat, input int hold_cycles, input logic [31:0] wbase);
        logic [31:0] exp_a [16];
        logic [31:0] wd [16];
        logic [1:0]  exp_t;
        bit exp_rej, d_pend, d_waited, consumed, fin;
        int n, beat_a, d_idx, estate, hold_left, done_n, err_n, rv_n, busy_n, done_cyc;

        n        = beats_of(burst);
        exp_rej  = model_reject(addr, burst);
        for (int k = 0; k < 16; k++) begin
            exp_a[k] = beat_addr(addr, burst, k);
            wd[k]    = wbase + 32'(k);
        end
        d_pend = 0; d_waited = 0; consumed = 0; fin = 0;
        beat_a = 0; d_idx = 0; estate = 0; hold_left = hold_cycles;
        done_n = 0; err_n = 0; rv_n = 0; busy_n = 0; done_cyc = -1;

        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_burst = burst;
        hready = 1'b1; hresp = 2'b00;
        @(negedge hclk);
        check("cmd_ready", cmd_ready, 1'b1);
        @(posedge hclk); #1;
        cmd_valid = 1'b0;

        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (consumed) begin
                wdata_valid = 1'b0;
                consumed    = 0;
            end
            if (wr && !exp_rej && !wdata_valid && beat_a < n) begin
                if (beat_a == hold_beat && hold_left > 0)
                    hold_left--;
                else if (int'($urandom_range(0, 99)) >= gap_pct) begin
                    wdata_valid = 1'b1;
                    wdata       = wd[beat_a];
                end
            end
            if (d_pend && d_idx == err_beat && estate == 0) begin
                hready = 1'b0; hresp = 2'b01; estate = 1;
            end else if (estate == 1) begin
                hready = 1'b1; hresp = 2'b01; estate = 2;
            end else begin
                hresp = 2'b00;
                if (wait_pct < 0) hready = !(d_pend && !d_waited);
                else              hready = (int'($urandom_range(0, 99)) >= wait_pct);
            end
            if (d_pend && !hready) d_waited = 1;
            hrdata = $urandom;

            @(negedge hclk);
            if (cyc == 0) check("cmd_err_next_cycle", cmd_err, exp_rej);
            if (done)        begin done_n++; done_cyc = cyc; end
            if (cmd_err)     err_n++;
            if (rdata_valid) rv_n++;
            if (htrans == HT_BUSY) busy_n++;

            exp_t = HT_IDLE;
            if (!exp_rej && beat_a < n && estate < 2) begin
                if (wr && !wdata_valid) exp_t = (beat_a == 0) ? HT_IDLE : HT_BUSY;
                else                    exp_t = (beat_a == 0) ? HT_NONSEQ : HT_SEQ;
            end
            check("htrans", htrans, exp_t);
            if (exp_t != HT_IDLE) begin
                check("haddr", haddr, exp_a[beat_a]);
                check("hburst", hburst, burst);
            end

            if (d_pend && hready) begin
                if (hresp == 2'b00) begin
                    if (wr) check("hwdata", hwdata, wd[d_idx]);
                    else begin
                        check("rdata_valid", rdata_valid, 1'b1);
                        check("rdata", rdata, hrdata);
                    end
                    check("done_on_last", done, (d_idx == n - 1));
                end
                d_pend = 0;
            end
            if (hready && htrans[1] && beat_a < n) begin
                if (wr) begin
                    check("wdata_ready", wdata_ready, 1'b1);
                    consumed = 1;
                end
                d_pend   = 1;
                d_waited = 0;
                d_idx    = beat_a;
                beat_a++;
            end
            if (done || cmd_err) fin = 1;
            @(posedge hclk); #1;
        end
        if (!fin) check("timeout", 1'b0, 1'b1);

        wdata_valid = 1'b0; hready = 1'b1; hresp = 2'b00;
        @(negedge hclk);
        check("ready_after", cmd_ready, 1'b1);
        check("idle_after", htrans, HT_IDLE);
        @(posedge hclk); #1;

        if (exp_rej) begin
            check("rej_err", err_n, 1);
            check("rej_done", done_n, 0);
            check("rej_beats", beat_a, 0);
        end else if (err_beat >= 0) begin
            check("buserr_err", err_n, 1);
            check("buserr_done", done_n, 0);
            check("buserr_beats", beat_a, err_beat + 1);
            check("buserr_rvalid", rv_n, wr ? 0 : err_beat);
        end else begin
            check("ok_done", done_n, 1);
            check("ok_err", err_n, 0);
            check("ok_beats", beat_a, n);
            check("ok_rvalid", rv_n, wr ? 0 : n);
            if (wait_pct == 0 && gap_pct == 0 && hold_cycles == 0)
                check("done_latency", done_cyc, n);
            if (hold_cycles > 0 && gap_pct == 0)
                check("busy_cycles", busy_n, hold_cycles);
        end
    endtask

    initial begin
        hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_burst = '0;
        wdata = '0; wdata_valid = 1'b0; hready = 1'b1; hresp = 2'b00; hrdata = '0;
        repeat (2) @(posedge hclk);
        #1;
        check_reset_vals("por");
        hresetn = 1'b1;
        @(negedge hclk);
        check("ready_after_por", cmd_ready, 1'b1);
        @(posedge hclk); #1;

        run_cmd(1'b1, 32'h0000_0004, 3'b000, -1, 0, 0, -1, 0, 32'h1);          // SINGLE write
        run_cmd(1'b0, 32'h0000_0010, 3'b011, -1, -1, 0, -1, 0, 32'h0);         // INCR4 read, 1 wait/beat
        run_cmd(1'b1, 32'h0000_0008, 3'b010, -1, 0, 0, 2, 2, 32'hA0);          // WRAP4 write, 2 BUSY
        run_cmd(1'b0, 32'h0000_3FF0, 3'b101, -1, 0, 0, -1, 0, 32'h0);          // INCR8 crossing 1 KB
        run_cmd(1'b1, 32'h0000_0200, 3'b011, 1, 0, 0, -1, 0, 32'hB0);          // ERROR on beat 2
        run_cmd(1'b0, 32'h0000_03F0, 3'b011, -1, 0, 0, -1, 0, 32'h0);          // INCR4 ends exactly at 1 KB
        run_cmd(1'b0, 32'h0000_0000, 3'b001, -1, 0, 0, -1, 0, 32'h0);          // INCR rejected
        run_cmd(1'b1, 32'h0000_0102, 3'b000, -1, 0, 0, -1, 0, 32'h0);          // unaligned
        run_cmd(1'b0, 32'h0000_0034, 3'b100, -1, 20, 0, -1, 0, 32'h0);         // WRAP8 read
        run_cmd(1'b0, 32'h0000_0040, 3'b111, 15, 10, 0, -1, 0, 32'h0);         // ERROR on final beat

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [2:0]  b;
            int          eb;
            b = 3'($urandom_range(0, 7));
            a = $urandom & 32'h0000_3FFC;
            if ($urandom_range(0, 3) == 0) a[9:6] = 4'hF;
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, beats_of(b) - 1)) : -1;
            run_cmd(1'($urandom_range(0, 1)), a, b, eb, int'($urandom_range(0, 40)),
                    int'($urandom_range(0, 40)), -1, 0, $urandom);
        end

        // Reset in the middle of an INCR16 read.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0100; cmd_burst = 3'b111;
        hready = 1'b1; hresp = 2'b00;
        @(posedge hclk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge hclk);
        #2;
        check("mid_busy", htrans, HT_SEQ);
        hresetn = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge hclk); #1;
        check_reset_vals("midrst_hold");
        hresetn = 1'b1;
        @(negedge hclk);
        check("ready_after_mid", cmd_ready, 1'b1);
        for (int c = 0; c < 3; c++) begin
            check("post_rst_idle", htrans, HT_IDLE);
            check("post_rst_done", done, 1'b0);
            check("post_rst_err", cmd_err, 1'b0);
            @(negedge hclk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
